// File: rtl/turtle_display_pkg.sv
// Shared constants and the hex-to-segment decode for the Basys3 4-digit display.
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package turtle_display_pkg;

    localparam int         NUM_DIGITS = 4;
    localparam logic [6:0] SEG_BLANK  = 7'b1111111;
    localparam logic [3:0] AN_OFF     = 4'b1111;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seven_seg_lzb_mask.sv
// Leading-zero blanking mask: digit d (1..3) is blanked when nibbles d..3 are all zero.
// Digit 0 is never blanked, so a zero word still shows a single "0".
module seven_seg_lzb_mask
    import turtle_display_pkg::*;
(
    input  logic [15:0] shadow,
    input  logic        lzb_en,
    output logic [3:0]  blank
);

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        blank = '0;
        for (int d = 1; d < NUM_DIGITS; d++) begin
            blank[d] = lzb_en && ((shadow >> (4 * d)) == 16'h0000);
        end
    end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed scan driver for the Basys3 common-anode display: shadowed per frame,
// dead time at the start of each digit slot, optional leading-zero blanking.
module seven_seg_scan_driver
    import turtle_display_pkg::*;
#(
    parameter int DIGIT_PERIOD = 100_000,
    parameter int DEAD_CYCLES  = 1_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic        lzb_en,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        frame_start
);

    localparam int CNT_W = $clog2(DIGIT_PERIOD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGIT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD_CYCLES);

    generate
        if (DIGIT_PERIOD < 2) begin : g_bad_period
            $error("seven_seg_scan_driver: DIGIT_PERIOD must be >= 2");
        end
        if (DEAD_CYCLES < 0 || DEAD_CYCLES >= DIGIT_PERIOD) begin : g_bad_dead
            $error("seven_seg_scan_driver: DEAD_CYCLES must satisfy 0 <= DEAD_CYCLES < DIGIT_PERIOD");
        end
    endgenerate

    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       digit, digit_nxt;
    logic [15:0]      shadow, shadow_nxt;
    logic [6:0]       seg_nxt;
    logic [3:0]       an_nxt;
    logic             frame_hit;
    logic [3:0]       blank;

    seven_seg_lzb_mask u_lzb_mask (
        .shadow (shadow),
        .lzb_en (lzb_en),
        .blank  (blank)
    );

    always_comb begin
        cnt_nxt    = cnt + CNT_W'(1);
        digit_nxt  = digit;
        frame_hit  = (cnt == '0) && (digit == 2'd0);
        shadow_nxt = shadow;
        an_nxt     = AN_OFF;
        seg_nxt    = SEG_BLANK;

        if (cnt == CNT_LAST) begin
            cnt_nxt   = '0;
            digit_nxt = digit + 2'd1;
        end

        if (frame_hit) begin
            shadow_nxt = value;
        end

        // Outputs see the pre-load shadow on the frame-start cycle; cnt==0 keeps that inside dead time.
        if (cnt >= CNT_DEAD && !blank[digit]) begin
            an_nxt  = ~(4'b0001 << digit);
            seg_nxt = hex_to_seg(shadow[4*digit +: 4]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            digit       <= 2'd0;
            shadow      <= 16'h0000;
            an          <= AN_OFF;
            seg         <= SEG_BLANK;
            frame_start <= 1'b0;
        end else begin
            cnt         <= cnt_nxt;
            digit       <= digit_nxt;
            shadow      <= shadow_nxt;
            an          <= an_nxt;
            seg         <= seg_nxt;
            frame_start <= frame_hit;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Self-checking bench for seven_seg_scan_driver with DIGIT_PERIOD=8, DEAD_CYCLES=2.
module tb_seven_seg_scan_driver;

    localparam int P  = 8;
    localparam int DC = 2;
    localparam int FR = 4 * P;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    localparam logic [3:0] AN_TAB [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] value = 16'h0000;
    logic        lzb_en = 1'b0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_start;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seven_seg_scan_driver #(
        .DIGIT_PERIOD (P),
        .DEAD_CYCLES  (DC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .value       (value),
        .lzb_en      (lzb_en),
        .seg         (seg),
        .an          (an),
        .frame_start (frame_start)
    );

    // Reference model: position within a 32-cycle frame, shadow captured at position 0.
    function automatic bit m_blank(input int d, input logic [15:0] sh, input logic lz);
        int top = 0;
        for (int i = 0; i < 4; i++) begin
            if (sh[4*i +: 4] != 4'h0) top = i;
        end
        return lz && (d > top);
    endfunction

    function automatic logic [3:0] m_an(input int p, input logic [15:0] sh, input logic lz);
        int d = p / P;
        int c = p % P;
        if (c < DC || m_blank(d, sh, lz)) return 4'b1111;
        return AN_TAB[d];
    endfunction

    function automatic logic [6:0] m_seg(input int p, input logic [15:0] sh, input logic lz);
        int d = p / P;
        int c = p % P;
        if (c < DC || m_blank(d, sh, lz)) return 7'b1111111;
        return SEG_TAB[sh[4*d +: 4]];
    endfunction

    int          m_pos = 0;
    logic [15:0] m_shadow = 16'h0000;
    logic [3:0]  exp_an = 4'b1111;
    logic [6:0]  exp_seg = 7'b1111111;
    logic        exp_fs = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_pos    <= 0;
            m_shadow <= 16'h0000;
            exp_an   <= 4'b1111;
            exp_seg  <= 7'b1111111;
            exp_fs   <= 1'b0;
        end else begin
            m_pos   <= (m_pos + 1) % FR;
            if (m_pos == 0) m_shadow <= value;
            exp_fs  <= (m_pos == 0);
            exp_an  <= m_an(m_pos, m_shadow, lzb_en);
            exp_seg <= m_seg(m_pos, m_shadow, lzb_en);
        end
    end

    always @(negedge clk) begin
        assert ($countones(~an) <= 1)
            else $error("FAIL an_onehot: an=%b has more than one digit low", an);
    end

    task automatic wait_cycle;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_reset;
        reset = 1'b1;
        wait_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset  = 1'b1;
        value  = 16'h1234;
        lzb_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wait_cycle();
            checks++;
            if (an !== 4'b1111 || seg !== 7'b1111111 || frame_start !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold[%0d]: an=%b seg=%b fs=%b, want 1111 1111111 0", i, an, seg, frame_start);
            end
        end
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            logic [3:0] ea;
            logic [6:0] es;
            wait_cycle();
            ea = (k < 2) ? 4'b1111 : 4'b1110;
            es = (k < 2) ? 7'b1111111 : 7'b0011001;
            checks++;
            if (an !== ea || seg !== es || frame_start !== (k == 0)) begin
                errors++;
                $display("FAIL reset_release[%0d]: an=%b seg=%b fs=%b, want %b %b %b", k, an, seg, frame_start, ea, es, k == 0);
            end
        end
    endtask

    task automatic test_scan;
        logic [15:0] sv = 16'h1234;
        value  = sv;
        lzb_en = 1'b0;
        pulse_reset();
        for (int k = 0; k < 2 * FR; k++) begin
            int p, d, c;
            logic [3:0] ea;
            logic [6:0] es;
            wait_cycle();
            p  = k % FR;
            d  = p / P;
            c  = p % P;
            ea = (c < DC) ? 4'b1111 : AN_TAB[d];
            es = (c < DC) ? 7'b1111111 : SEG_TAB[sv[4*d +: 4]];
            checks++;
            if (an !== ea || seg !== es || frame_start !== (p == 0)) begin
                errors++;
                $display("FAIL scan[%0d]: an=%b seg=%b fs=%b, want %b %b %b", k, an, seg, frame_start, ea, es, p == 0);
            end
        end
    endtask

    task automatic test_tear_free;
        value  = 16'h1234;
        lzb_en = 1'b0;
        pulse_reset();
        for (int k = 0; k < 2 * FR; k++) begin
            int p, d, c;
            logic [15:0] sv;
            logic [3:0]  ea;
            logic [6:0]  es;
            wait_cycle();
            p  = k % FR;
            d  = p / P;
            c  = p % P;
            sv = (k < FR) ? 16'h1234 : 16'hABCD;
            ea = (c < DC) ? 4'b1111 : AN_TAB[d];
            es = (c < DC) ? 7'b1111111 : SEG_TAB[sv[4*d +: 4]];
            checks++;
            if (an !== ea || seg !== es) begin
                errors++;
                $display("FAIL tear_free[%0d]: an=%b seg=%b, want %b %b", k, an, seg, ea, es);
            end
            if (k == 10) value = 16'hABCD;
        end
    endtask

    task automatic test_lzb;
        logic [15:0] vals [2] = '{16'h0050, 16'h0000};
        logic [3:0]  vis  [2] = '{4'b0011, 4'b0001};
        lzb_en = 1'b1;
        for (int t = 0; t < 2; t++) begin
            value = vals[t];
            pulse_reset();
            for (int k = 0; k < FR; k++) begin
                int d, c;
                logic [3:0] ea;
                logic [6:0] es;
                wait_cycle();
                d  = k / P;
                c  = k % P;
                ea = (c < DC || !vis[t][d]) ? 4'b1111 : AN_TAB[d];
                es = (c < DC || !vis[t][d]) ? 7'b1111111 : SEG_TAB[vals[t][4*d +: 4]];
                checks++;
                if (an !== ea || seg !== es) begin
                    errors++;
                    $display("FAIL lzb[%h][%0d]: an=%b seg=%b, want %b %b", vals[t], k, an, seg, ea, es);
                end
            end
        end
        lzb_en = 1'b0;
    endtask

    task automatic test_mid_reset;
        value  = 16'h1234;
        lzb_en = 1'b0;
        pulse_reset();
        repeat (21) wait_cycle();
        checks++;
        if (an !== 4'b1011) begin
            errors++;
            $display("FAIL mid_reset_pre: an=%b, want 1011", an);
        end
        reset = 1'b1;
        wait_cycle();
        checks++;
        if (an !== 4'b1111 || seg !== 7'b1111111 || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_hold: an=%b seg=%b fs=%b, want 1111 1111111 0", an, seg, frame_start);
        end
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            logic [3:0] ea;
            wait_cycle();
            ea = (k < 2) ? 4'b1111 : 4'b1110;
            checks++;
            if (an !== ea || frame_start !== (k == 0)) begin
                errors++;
                $display("FAIL mid_reset_restart[%0d]: an=%b fs=%b, want %b %b", k, an, frame_start, ea, k == 0);
            end
        end
    endtask

    task automatic test_random;
        int last_fs = -1;
        value  = 16'($urandom);
        lzb_en = 1'b0;
        pulse_reset();
        for (int i = 0; i < 10000; i++) begin
            wait_cycle();
            checks++;
            if (an !== exp_an || seg !== exp_seg || frame_start !== exp_fs) begin
                errors++;
                $display("FAIL random[%0d]: an=%b seg=%b fs=%b, want %b %b %b", i, an, seg, frame_start, exp_an, exp_seg, exp_fs);
            end
            checks++;
            if ($countones(~an) > 1) begin
                errors++;
                $display("FAIL random_onehot[%0d]: an=%b, want at most one low", i, an);
            end
            if (frame_start === 1'b1) begin
                if (last_fs >= 0) begin
                    checks++;
                    if (i - last_fs != FR) begin
                        errors++;
                        $display("FAIL frame_period[%0d]: period=%0d, want %0d", i, i - last_fs, FR);
                    end
                end
                last_fs = i;
            end
            value = 16'($urandom) >> (4 * $urandom_range(0, 4));
            if ($urandom_range(0, 63) == 0) lzb_en = ~lzb_en;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_scan();
        test_tear_free();
        test_lzb();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
